// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter
// Shares a single-port, one-cycle-read-latency TCM between NUM_REQ bus
// requesters (0 = UART boot loader, 1 = core load/store, 2 = core fetch).
// One access is issued per cycle. Read data comes back one cycle after
// acceptance, tagged to the requester that issued it.
//
// Build option:
//   TCM_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration, starting
//                                        after the last-granted index
//                           undefined -> fixed priority (index 0 highest)
//                                        with a per-requester starvation guard
module tcm_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_be,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            tcm_en,
    output logic [DATA_WIDTH/8-1:0]         tcm_we,
    output logic [ADDR_WIDTH-1:0]           tcm_addr,
    output logic [DATA_WIDTH-1:0]           tcm_wdata,
    input  logic [DATA_WIDTH-1:0]           tcm_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]    grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;

    // Last driven address/data, so the TCM pins stay quiet on idle cycles.
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] wdata_hold_q, wdata_hold_d;

    // One-hot owner of the read issued last cycle.
    logic [NUM_REQ-1:0]    tag_q, tag_d;

`ifdef TCM_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rr_found;
    int               rr_idx;

    // Round-robin: first valid requester after the last-granted index.
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!rr_found && req_valid[rr_idx]) begin
                grant[rr_idx] = 1'b1;
                rr_found      = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    // Pointer moves only when something is granted.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                ptr_d = PTR_W'(i);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt_q [NUM_REQ];
    logic [7:0] cnt_d [NUM_REQ];
    logic       fp_found;

    // Starved requesters (lowest index first) beat everyone; otherwise the
    // lowest valid index wins.
    always_comb begin
        grant    = '0;
        fp_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fp_found && req_valid[i] && (cnt_q[i] >= LIMIT)) begin
                grant[i] = 1'b1;
                fp_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fp_found && req_valid[i]) begin
                grant[i] = 1'b1;
                fp_found = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    // Wait counters: count denied valid cycles, saturate, clear otherwise.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = 8'd0;
            if (req_valid[i] && !grant[i]) begin
                cnt_d[i] = (cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    // Steer the granted requester's fields onto the TCM side.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_be    = req_be[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    assign req_ready = grant;
    assign tcm_en    = |grant;
    assign tcm_we    = (tcm_en && sel_we) ? sel_be : '0;
    assign tcm_addr  = tcm_en ? sel_addr  : addr_hold_q;
    assign tcm_wdata = tcm_en ? sel_wdata : wdata_hold_q;

    // Read data is a straight pass-through of the macro output.
    assign rsp_valid = tag_q;
    assign rsp_rdata = tcm_rdata;

    // Next-state for the issue tag and the idle hold registers.
    always_comb begin
        tag_d        = (tcm_en && !sel_we) ? grant : '0;
        addr_hold_d  = tcm_en ? sel_addr  : addr_hold_q;
        wdata_hold_d = tcm_en ? sel_wdata : wdata_hold_q;
    end

    // Issue tag and hold registers; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q        <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            tag_q        <= tag_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Arbitrates a single-port, one-cycle-read-latency tightly coupled memory (TCM) in the SoC between NUM_REQ requesters: index 0 UART boot loader, index 1 core load/store, index 2 core instruction fetch. One access is issued per cycle using fixed priority with a starvation guard. Each read's data is returned one cycle after acceptance to the requester that issued it. The block sits between the core/loader bus ports and the TCM macro inside the SoC top.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 has highest fixed priority
- ADDR_WIDTH, 14, TCM word address width
- DATA_WIDTH, 32, data width; multiple of 8
- STARVE_LIMIT, 8, consecutive denied valid cycles before a requester is forced to the top; range 1..255

Ports (clock and reset first):
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed word addresses; requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_be  in  NUM_REQ*DATA_WIDTH/8  packed byte enables; ignored for reads
- req_ready  out  NUM_REQ  one-hot grant; same-cycle acceptance
- rsp_valid  out  NUM_REQ  one-hot read-data valid
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- tcm_en  out  1  TCM access enable
- tcm_we  out  DATA_WIDTH/8  byte write enables; all zero for reads
- tcm_addr  out  ADDR_WIDTH  TCM address
- tcm_wdata  out  DATA_WIDTH  TCM write data
- tcm_rdata  in  DATA_WIDTH  TCM read data, valid one cycle after a read with tcm_en=1

## Operation
- Grant is combinational from req_valid and registered state. At most one req_ready bit is high per cycle; a bit is high only when the matching req_valid is high.
- An access is accepted when req_valid[i] & req_ready[i]. In that same cycle, tcm_en=1 and the TCM address, data and enable outputs carry requester i's fields. tcm_we = req_be[i] when req_we[i], else 0.
- With no grant: tcm_en=0 and tcm_we=0. tcm_addr and tcm_wdata are don't-care; they hold the last driven value.
- Requesters hold valid, address and data stable until accepted. The arbiter never takes back a grant in the same cycle.
- Fixed priority: the lowest valid index wins unless the starvation guard is active.
- Starvation guard: there is one 8-bit wait counter per requester.
  - The counter increments when valid and not granted, saturating at 255.
  - It clears when the requester is granted or its valid is low.
  - Any requester whose counter is >= STARVE_LIMIT is "starved". Among starved requesters the lowest index wins, ahead of all non-starved ones.
- Read response: a registered one-hot issue tag is set from the granted index when the accepted access is a read.
  - Next cycle, rsp_valid = that tag and rsp_rdata = tcm_rdata, unregistered pass-through.
  - Write acceptance produces no rsp_valid; writes are complete on acceptance.
- Back-to-back reads from any mix of requesters are sustained at 1 per cycle. A read followed by a write in the next cycle is legal, with no turnaround.

## Timing
- Reset values: req_ready=0 while rst is high; rsp_valid=0; issue tag=0; all wait counters=0; round-robin pointer=0; tcm_en=0; tcm_we=0.
- Accept-to-TCM latency: 0 cycles, combinational. Read latency: accept at cycle N, rsp_valid at cycle N+1.
- Reset asserted mid-operation: any in-flight read response is dropped, so rsp_valid is 0 in the following cycle. No partial state survives.
- Simultaneous events: a counter reaching STARVE_LIMIT in cycle N forces a grant in cycle N+1 at the latest.
- Worst-case wait for any continuously valid requester with the guard enabled: STARVE_LIMIT + NUM_REQ - 1 cycles.

## Configuration
- TCM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration replaces fixed priority and the starvation guard.
  - A pointer register holds the last-granted index. The search starts at pointer+1 mod NUM_REQ and takes the first valid requester.
  - The pointer updates only on a grant. Wait counters are not implemented.
- TCM_ARB_ROUND_ROBIN_EN undefined: fixed priority plus starvation guard, as described above.

## Test plan
- Reset: hold rst high with all req_valid=1 -> req_ready=0, tcm_en=0, rsp_valid=0. Deassert rst -> req_ready=3'b001 in the first cycle.
- Single read: requester 1 reads addr 0x010, TCM preloaded with 0xDEADBEEF -> tcm_en=1 and tcm_addr=0x010 in cycle N; rsp_valid=3'b010 and rsp_rdata=0xDEADBEEF in cycle N+1.
- Byte write then read: requester 0 writes 0x11223344 with be=4'b0011 to addr 0x020, which holds 0xAAAAAAAA -> tcm_we=4'b0011 and no rsp_valid. A later read returns 0xAAAA3344.
- Starvation, fixed priority: requesters 0 and 2 held valid continuously, STARVE_LIMIT=8 -> requester 2 is granted within 9 cycles of first assertion and its counter clears. Requester 0 then resumes.
- Mixed pipeline: reads from 2, 1, 0 accepted on consecutive cycles -> rsp_valid sequence 100, 010, 001 with matching data on the following cycles. Reset asserted after the second accept -> no further rsp_valid.
- With TCM_ARB_ROUND_ROBIN_EN: all three valid for 6 cycles -> grant order 1, 2, 0, 1, 2, 0.
